// File: rtl/rand_delay_pkg.sv
// Shared types and defaults for the random-latency holding slot.
package rand_delay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_e;

  localparam int DATA_W_DEF  = 32;
  localparam int DELAY_W_DEF = 4;
  localparam int LFSR_W_DEF  = 16;

  // Stall statistics counter (only built with RAND_DELAY_STAT_EN)
  localparam int                STAT_W   = 32;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

endpackage

// File: rtl/rand_delay_slot_if.sv
// Upstream/downstream valid-ready bus of the random-latency slot.
// slave: the slot itself; master: whatever drives and drains it.
interface rand_delay_slot_if #(
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/rand_delay_counter.sv
// Load/decrement delay counter. Decrement saturates at zero so the
// counter can never wrap; o_last flags the final wait cycle (cnt==1).
module rand_delay_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_cnt,
  output logic         o_last
);
  logic [W-1:0] r_cnt;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                        r_cnt <= '0;
    else if (i_load)                   r_cnt <= i_d;
    else if (i_dec && (r_cnt != '0))   r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == W'(1));
endmodule

// File: rtl/rand_delay_slot.sv
// Single-entry valid/ready slot that holds each accepted transaction for
// a pseudorandom number of cycles (low DELAY_W bits of the LFSR state at
// acceptance) before presenting it downstream. Used to inject random
// latency on response paths for stress testing.
// Optional build macro: RAND_DELAY_STAT_EN adds the stall_cycles counter.
module rand_delay_slot
  import rand_delay_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int LFSR_W  = LFSR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LFSR_W-1:0] lfsr_in,
`ifdef RAND_DELAY_STAT_EN
  output logic [STAT_W-1:0] stall_cycles,
`endif
  rand_delay_slot_if.slave  bus
);
  state_e              r_state;
  state_e              w_state_nx;
  logic [DATA_W-1:0]   r_data_q;
  logic [DELAY_W-1:0]  w_d;
  logic [DELAY_W-1:0]  w_cnt;
  logic                w_last;
  logic                w_load;
  logic                w_dec;
  logic                w_capture;
  logic                w_unused_lfsr;

  // Only the low DELAY_W bits of the LFSR state matter here.
  assign w_d           = lfsr_in[DELAY_W-1:0];
  assign w_unused_lfsr = ^lfsr_in;

  rand_delay_counter #(.W(DELAY_W)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_load),
    .i_dec  (w_dec),
    .i_d    (w_d),
    .o_cnt  (w_cnt),
    .o_last (w_last)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state and counter/capture controls.
  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_capture = 1'b1;
          if (w_d == '0) begin
            w_state_nx = SEND;
          end else begin
            w_load     = 1'b1;
            w_state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        w_dec = 1'b1;
        // cnt==0 cannot occur in WAIT; treat it as done rather than hang.
        if (w_last || (w_cnt == '0)) w_state_nx = SEND;
      end
      SEND: begin
        if (bus.out_ready) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Payload register: captured only at acceptance, held otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_data_q <= '0;
    else if (w_capture) r_data_q <= bus.in_data;
  end

  // Outputs decode from registered state only.
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == SEND);
  assign bus.out_data  = r_data_q;

`ifdef RAND_DELAY_STAT_EN
  logic [STAT_W-1:0] r_stall;

  // Count cycles spent waiting or backpressured, saturating.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (((r_state == WAIT) || ((r_state == SEND) && !bus.out_ready))
                 && (r_stall != STAT_MAX)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_rand_delay_slot.sv
// Scoreboard bench for rand_delay_slot: acceptances push the expected
// payload and first-valid cycle; a monitor checks deliveries in order.
module tb_rand_delay_slot;
  import rand_delay_pkg::*;

  localparam int DATA_W  = 32;
  localparam int DELAY_W = 4;
  localparam int LFSR_W  = 16;
  localparam int N_SOAK  = 1000;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [LFSR_W-1:0] lfsr_in;
  logic [LFSR_W-1:0] lfsr_q   = 16'hACE1;
  logic [LFSR_W-1:0] lfsr_dir = '0;
  logic              use_lfsr = 1'b0;
`ifdef RAND_DELAY_STAT_EN
  logic [STAT_W-1:0] stall_cycles;
  logic [STAT_W-1:0] stall0;
`endif

  rand_delay_slot_if #(.DATA_W(DATA_W)) bus ();

  rand_delay_slot #(.DATA_W(DATA_W), .DELAY_W(DELAY_W), .LFSR_W(LFSR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .lfsr_in      (lfsr_in),
`ifdef RAND_DELAY_STAT_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus.slave)
  );

  always #5 clock = ~clock;

  // Free-running 16-bit maximal Fibonacci LFSR (x^16+x^14+x^13+x^11+1).
  always @(posedge clock)
    lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  assign lfsr_in = use_lfsr ? lfsr_q : lfsr_dir;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                first_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_fail = 0, n_acc = 0, n_deliv = 0;
  logic soak_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus side: an acceptance seen now happens at the next edge, so
  // the transaction must first be valid d+1 cycles after this one.
  always @(negedge clock) begin
    if (reset && bus.in_valid && bus.in_ready) begin
      sb.push_back('{bus.in_data, cyc + 1 + int'(lfsr_in[DELAY_W-1:0])});
      n_acc++;
    end
  end

  // Output monitor.
  logic prev_ov = 1'b0;
  always @(negedge clock) begin
    if (!reset) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
        end else begin
          if (!prev_ov) begin
            check("latency", 64'(cyc), 64'(sb[0].first_cyc));
            check("out_data", 64'(bus.out_data), 64'(sb[0].data));
          end else begin
            check("hold_stable", 64'(bus.out_data), 64'(sb[0].data));
          end
          if (bus.out_ready) begin
            void'(sb.pop_front());
            n_deliv++;
          end
        end
      end
      prev_ov = bus.out_valid && !bus.out_ready;
    end
  end

  // Present one transaction and hold it until accepted (bounded).
  task automatic send(input logic [DATA_W-1:0] data, input logic [LFSR_W-1:0] lf);
    bit ok = 0;
    lfsr_dir     = lf;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = bus.in_ready;
    end
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~data;
  endtask

  task automatic wait_drain(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clock);
      ok = (sb.size() == 0);
    end
    if (!ok) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
`ifdef RAND_DELAY_STAT_EN
    check("rst_stall", 64'(stall_cycles), 64'd0);
`endif
    @(posedge clock); #1;

    // Zero delay: valid only in the cycle after acceptance.
    bus.out_ready = 1'b1;
    send(32'hDEAD_BEEF, 16'hFFF0);
    @(negedge clock);
    check("zd_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clock);
    check("zd_valid_drop", 64'(bus.out_valid), 64'd0);
    check("zd_in_ready",   64'(bus.in_ready),  64'd1);
    @(posedge clock); #1;

    // Max delay: in_valid held high all through WAIT/SEND is refused.
    send(32'h1234_5678, 16'h000F);
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hBAD0_0000 + 32'(i);
      @(negedge clock);
      check("maxd_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    wait_drain(20);
    check("maxd_in_ready_back", 64'(bus.in_ready), 64'd1);
    @(posedge clock); #1;

    // Backpressure: d=3, five cycles of out_ready=0 in SEND.
    bus.out_ready = 1'b0;
`ifdef RAND_DELAY_STAT_EN
    stall0 = stall_cycles;
`endif
    send(32'hCAFE_F00D, 16'h0003);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clock);
        seen = bus.out_valid;
      end
      check("bp_reach_send", 64'(seen), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_valid_held", 64'(bus.out_valid), 64'd1);
      check("bp_data_held",  64'(bus.out_data),  64'hCAFE_F00D);
    end
    @(posedge clock); #1;
    bus.out_ready = 1'b1;
    wait_drain(5);
`ifdef RAND_DELAY_STAT_EN
    @(negedge clock);
    check("bp_stall", 64'(stall_cycles - stall0), 64'd8);
`endif
    @(posedge clock); #1;

    // Reset in the 4th WAIT cycle of a d=9 transaction.
    send(32'h55AA_55AA, 16'h0009);
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("mid_rst_out_data",  64'(bus.out_data),  64'd0);
    sb.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      check("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
    end
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clock); #1;

    // Soak with the real LFSR and random backpressure.
    use_lfsr = 1'b1;
    fork
      begin
        for (int i = 0; i < N_SOAK; i++) send($urandom, '0);
        wait_drain(200);
        soak_done = 1'b1;
      end
      begin
        while (!soak_done) begin
          @(posedge clock); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);

    check("accepted_count",  64'(n_acc),   64'(N_SOAK + 4));
    check("delivered_count", 64'(n_deliv), 64'(N_SOAK + 3));
    check("sb_empty",        64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
